// File: rtl/ttsweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings,
// default sizing and the settle-counter width helper.
package ttsweep_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Default sizing for the lab's 4-input circuits
  localparam int N_IN_DEF        = 4;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int TT_WIDTH        = 2 ** N_IN_DEF;
  localparam int HOLD_W          = $clog2(HOLD_CYCLES_DEF + 1);

  // Width of a counter that must be able to hold the value hold_cycles.
  // Clamped to 1 so an illegal setting still elaborates far enough to hit
  // the explicit error in the settle timer.
  function automatic int hold_width(input int hold_cycles);
    if (hold_cycles < 1) begin
      return 1;
    end else begin
      return $clog2(hold_cycles + 1);
    end
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: load/enable counter that measures how long the current
// input vector has been held. tc is high during the last settle cycle, so
// the FSM moves to SAMPLE on the edge that completes HOLD_CYCLES cycles.
module settle_timer
  import ttsweep_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_W       = hold_width(HOLD_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] count_r;

  // A zero-length settle window would sample before the circuit responds.
  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("settle_timer: HOLD_CYCLES must be at least 1");
    end
  endgenerate

  // Hold counter: cleared by load, advances while enabled, saturates at HOLD_CYCLES
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Terminal count: this enabled cycle is the last one of the settle window
  always_comb begin
    tc = 1'b0;
    if (en && (count_r == CNT_LAST)) begin
      tc = 1'b1;
    end else begin
      tc = 1'b0;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector of a small combinational
// circuit in ascending order, lets each settle for HOLD_CYCLES cycles,
// samples the circuit's Y into table_o and flags completion on done.
//
// Optional feature macro: TT_EXPECT_CHECK_EN
//   When defined, adds expected_i (golden table) and mismatch. mismatch is
//   evaluated together with done, once the final sample has landed.
//
// Timing: the last SAMPLE edge moves the FSM into DONE; done (and mismatch)
// are published on the following edge so they always describe the complete
// table. done therefore rises 16*(HOLD_CYCLES+1)+1 edges after start is seen.
module truth_table_sweeper
  import ttsweep_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int N_IN        = N_IN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        vec_o,
  input  logic                   y_i,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_o
`ifdef TT_EXPECT_CHECK_EN
  ,
  input  logic [(2**N_IN)-1:0]   expected_i,
  output logic                   mismatch
`endif
);

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  logic [1:0] state_r;
  logic       timer_load_s;
  logic       timer_en_s;
  logic       timer_tc_s;
  logic       start_ok_s;

  // Timer control: count only while settling and not being cancelled
  always_comb begin
    timer_load_s = 1'b1;
    timer_en_s   = 1'b0;
    if (state_r == ST_SETTLE) begin
      timer_load_s = 1'b0;
      timer_en_s   = ~abort;
    end else begin
      timer_load_s = 1'b1;
      timer_en_s   = 1'b0;
    end
  end

  // A new sweep is accepted only when no cancel is requested in the same cycle
  always_comb begin
    start_ok_s = 1'b0;
    if (start && !abort) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
  end

  settle_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load_s),
    .en    (timer_en_s),
    .tc    (timer_tc_s)
  );

  // Sweep FSM, vector counter, table register and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      vec_o    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      table_o  <= '0;
`ifdef TT_EXPECT_CHECK_EN
      mismatch <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            // Fresh sweep: forget the previous table and status
            state_r  <= ST_SETTLE;
            vec_o    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            table_o  <= '0;
`ifdef TT_EXPECT_CHECK_EN
            mismatch <= 1'b0;
`endif
          end else if ((state_r == ST_DONE) && !done) begin
            // First cycle in DONE: the table is complete, publish it
            done     <= 1'b1;
`ifdef TT_EXPECT_CHECK_EN
            mismatch <= (table_o != expected_i);
`endif
          end else begin
            state_r <= state_r;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            // Cancel: partial table is kept for inspection
            state_r <= ST_IDLE;
            vec_o   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (timer_tc_s) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_SETTLE;
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            // Cancel wins over the pending sample of this vector
            state_r <= ST_IDLE;
            vec_o   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else begin
            table_o[vec_o] <= y_i;
            if (vec_o == VEC_LAST) begin
              // Last vector sampled: park the vector at 0, never wrap past it
              state_r <= ST_DONE;
              vec_o   <= '0;
              busy    <= 1'b0;
            end else begin
              state_r <= ST_SETTLE;
              vec_o   <= vec_o + N_IN'(1);
            end
          end
        end

        default: begin
          // Unreachable encoding: recover to a quiet idle state
          state_r <= ST_IDLE;
          vec_o   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. Two instances: one with
// HOLD_CYCLES=4 driving a circuit_a stand-in (Y = ~A & D), one with
// HOLD_CYCLES=1 and Y tied high. Expected values go into a scoreboard queue
// as stimulus is applied and are popped when the DUT output is sampled.
module tb_truth_table_sweeper;

  localparam int LAT_LIMIT = 400;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start4, abort4, start1, abort1;
  logic [3:0]  vec4, vec1;
  logic        y4;
  logic        busy4, done4, busy1, done1;
  logic [15:0] table4, table1;
`ifdef TT_EXPECT_CHECK_EN
  logic [15:0] expected4, expected1;
  logic        mismatch4, mismatch1;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Lab circuit_a: Y = ~A & D with A = bit3, D = bit0
  function automatic logic circuit_a(input logic [3:0] v);
    return ~v[3] & v[0];
  endfunction

  assign y4 = circuit_a(vec4);

  truth_table_sweeper #(.HOLD_CYCLES(4), .N_IN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .abort      (abort4),
    .vec_o      (vec4),
    .y_i        (y4),
    .busy       (busy4),
    .done       (done4),
    .table_o    (table4)
`ifdef TT_EXPECT_CHECK_EN
    ,
    .expected_i (expected4),
    .mismatch   (mismatch4)
`endif
  );

  truth_table_sweeper #(.HOLD_CYCLES(1), .N_IN(4)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .abort      (abort1),
    .vec_o      (vec1),
    .y_i        (1'b1),
    .busy       (busy1),
    .done       (done1),
    .table_o    (table1)
`ifdef TT_EXPECT_CHECK_EN
    ,
    .expected_i (expected1),
    .mismatch   (mismatch1)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait somewhere fails to terminate
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_value("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_value(e.tag, got, e.val);
    end
  endtask

  // Advance one edge and settle past it before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden table of the HOLD=4 instance's circuit
  function automatic logic [15:0] golden_a();
    logic [15:0] t;
    t = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      t[k] = circuit_a(4'(k));
    end
    return t;
  endfunction

  // Run one sweep; lat = edges from the start-sampling edge to done high.
  task automatic sweep(input bit use1, input int restart_at, input bit track_vec, output int lat);
    int hold;
    int per_sweep;
    hold      = use1 ? 1 : 4;
    per_sweep = 16 * (hold + 1);
    if (use1) start1 = 1'b1; else start4 = 1'b1;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    lat    = 0;
    exp_push("busy_after_start", 32'd1);
    sb_compare(32'(use1 ? busy1 : busy4));
    exp_push("done_cleared", 32'd0);
    sb_compare(32'(use1 ? done1 : done4));
    while (((use1 ? done1 : done4) !== 1'b1) && (lat < LAT_LIMIT)) begin
      if (!use1 && (lat == restart_at)) start4 = 1'b1;
      else start4 = 1'b0;
      if (track_vec && (lat + 1 <= per_sweep)) begin
        exp_push("vec_step", (lat + 1 < per_sweep) ? 32'((lat + 1) / (hold + 1)) : 32'd0);
      end
      tick();
      lat++;
      start4 = 1'b0;
      if (track_vec && (lat <= per_sweep)) begin
        sb_compare(32'(use1 ? vec1 : vec4));
      end
    end
  endtask

  task automatic after_sweep(input bit use1, input int lat, input logic [15:0] tbl);
    int hold;
    hold = use1 ? 1 : 4;
    exp_push("done_latency", 32'(16 * (hold + 1) + 1));
    sb_compare(32'(lat));
    exp_push("table", 32'(tbl));
    sb_compare(32'(use1 ? table1 : table4));
    exp_push("vec_after_done", 32'd0);
    sb_compare(32'(use1 ? vec1 : vec4));
    exp_push("busy_after_done", 32'd0);
    sb_compare(32'(use1 ? busy1 : busy4));
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    start4 = 1'b0;
    abort4 = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
`ifdef TT_EXPECT_CHECK_EN
    expected4 = 16'h00AA;
    expected1 = 16'hFFFF;
`endif

    // Reset values after two reset edges
    tick();
    tick();
    exp_push("rst_vec", 32'd0);       sb_compare(32'(vec4));
    exp_push("rst_busy", 32'd0);      sb_compare(32'(busy4));
    exp_push("rst_done", 32'd0);      sb_compare(32'(done4));
    exp_push("rst_table", 32'h0);     sb_compare(32'(table4));
    exp_push("rst_table_h1", 32'h0);  sb_compare(32'(table1));
    rst_n = 1'b1;
    tick();

    // Full sweep against circuit_a, HOLD=4
    sweep(1'b0, -1, 1'b1, lat);
    after_sweep(1'b0, lat, golden_a());
    exp_push("table_const_a", 32'h0000_00AA);
    sb_compare(32'(table4));
    // done is a level: still high a few cycles later
    repeat (3) tick();
    exp_push("done_held", 32'd1);
    sb_compare(32'(done4));
    // abort in DONE has no effect
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    exp_push("abort_in_done", 32'd1);
    sb_compare(32'(done4));

    // Restart from DONE with a stray start pulse in SETTLE
    sweep(1'b0, 2, 1'b0, lat);
    after_sweep(1'b0, lat, 16'h00AA);

    // HOLD=1 with Y tied high; vector stepping tracked each edge
    sweep(1'b1, -1, 1'b1, lat);
    after_sweep(1'b1, lat, 16'hFFFF);

    // Abort sampled at edge 20 after start, just as vector 3 would be sampled
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (19) tick();
    abort4 = 1'b1;
    tick();
    exp_push("abort_busy", 32'd0);     sb_compare(32'(busy4));
    exp_push("abort_done", 32'd0);     sb_compare(32'(done4));
    exp_push("abort_vec", 32'd0);      sb_compare(32'(vec4));
    exp_push("abort_table", 32'h0002); sb_compare(32'(table4));
    // abort held in IDLE changes nothing
    tick();
    abort4 = 1'b0;
    exp_push("abort_idle_table", 32'h0002); sb_compare(32'(table4));

    // start together with abort: abort wins, sweep does not begin
    start4 = 1'b1;
    abort4 = 1'b1;
    tick();
    start4 = 1'b0;
    abort4 = 1'b0;
    exp_push("start_abort_busy", 32'd0);   sb_compare(32'(busy4));
    exp_push("start_abort_table", 32'h0002); sb_compare(32'(table4));

    // Reset mid-sweep wipes the partial table (vectors 0..5 sampled by edge 30)
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (30) tick();
    exp_push("partial_table", 32'h002A); sb_compare(32'(table4));
    rst_n = 1'b0;
    tick();
    exp_push("midrst_table", 32'h0); sb_compare(32'(table4));
    exp_push("midrst_vec", 32'd0);   sb_compare(32'(vec4));
    exp_push("midrst_busy", 32'd0);  sb_compare(32'(busy4));
    rst_n = 1'b1;
    tick();

`ifdef TT_EXPECT_CHECK_EN
    // Golden compare: matching and off-by-one-bit expectations
    expected4 = 16'h00AA;
    sweep(1'b0, -1, 1'b0, lat);
    after_sweep(1'b0, lat, 16'h00AA);
    exp_push("mismatch_clean", 32'd0);
    sb_compare(32'(mismatch4));
    expected4 = 16'h00AB;
    sweep(1'b0, -1, 1'b0, lat);
    after_sweep(1'b0, lat, 16'h00AA);
    exp_push("mismatch_flagged", 32'd1);
    sb_compare(32'(mismatch4));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
